// File: rtl/id_pkg.sv
// Shared decode constants and payload types for the RV32I ID/EX stage.
package id_pkg;

    localparam int unsigned ID_XLEN = 32;
    localparam int unsigned ID_RA_W = 5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SRL  = 3'b101;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH
    } imm_type_e;

    typedef enum logic [1:0] {
        SRC1_RS,
        SRC1_PC,
        SRC1_ZERO
    } src1_e;

    typedef struct packed {
        logic [6:0]         aluop;
        logic [2:0]         alusel;
        logic [6:0]         aluc;
        logic [ID_XLEN-1:0] imm;
        src1_e              src1;
        logic               reg2_rs;
        logic               use_rs1;
        logic               use_rs2;
        logic               wreg;
        logic               wmem;
        logic               rmem;
        logic               illegal;
    } id_ctrl_t;

    typedef struct packed {
        logic [ID_XLEN-1:0] pc;
        logic [6:0]         aluop;
        logic [2:0]         alusel;
        logic [6:0]         aluc;
        logic [ID_XLEN-1:0] reg1;
        logic [ID_XLEN-1:0] reg2;
        logic [ID_XLEN-1:0] imm;
        logic [ID_RA_W-1:0] wd;
        logic               wreg;
        logic               wmem;
        logic               rmem;
        logic               illegal;
    } id_ex_t;

endpackage

// File: rtl/id_decode.sv
// Pure combinational RV32I instruction decoder (inst -> control + immediate).
// ID_MULDIV_EN: accept RV32M encodings (OP with funct7=0000001).
module id_decode
    import id_pkg::*;
(
    input  logic [31:0] inst_i,
    output id_ctrl_t    ctrl_o
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       muldiv_ok;
    imm_type_e  imm_type;

    always_comb begin
        opc       = inst_i[6:0];
        f3        = inst_i[14:12];
        f7        = inst_i[31:25];
`ifdef ID_MULDIV_EN
        muldiv_ok = (f7 == F7_MULDIV);
`else
        muldiv_ok = 1'b0;
`endif
        imm_type       = IMM_NONE;
        ctrl_o         = '0;
        ctrl_o.aluop   = opc;
        ctrl_o.alusel  = f3;
        ctrl_o.src1    = SRC1_RS;

        case (opc)
            OPC_OP_IMM: begin
                ctrl_o.use_rs1 = 1'b1;
                ctrl_o.wreg    = 1'b1;
                if (f3 == F3_SLL || f3 == F3_SRL) begin
                    imm_type    = IMM_SH;
                    ctrl_o.aluc = f7;
                end else begin
                    imm_type = IMM_I;
                end
            end
            OPC_OP: begin
                ctrl_o.use_rs1 = 1'b1;
                ctrl_o.use_rs2 = 1'b1;
                ctrl_o.reg2_rs = 1'b1;
                ctrl_o.wreg    = 1'b1;
                ctrl_o.aluc    = f7;
                if (!((f7 == F7_BASE) ||
                      (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL)) ||
                      muldiv_ok))
                    ctrl_o.illegal = 1'b1;
            end
            OPC_LUI: begin
                ctrl_o.src1 = SRC1_ZERO;
                ctrl_o.wreg = 1'b1;
                imm_type    = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl_o.src1 = SRC1_PC;
                ctrl_o.wreg = 1'b1;
                imm_type    = IMM_U;
            end
            OPC_LOAD: begin
                ctrl_o.use_rs1 = 1'b1;
                ctrl_o.wreg    = 1'b1;
                ctrl_o.rmem    = 1'b1;
                imm_type       = IMM_I;
                if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                    ctrl_o.illegal = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.use_rs1 = 1'b1;
                ctrl_o.use_rs2 = 1'b1;
                ctrl_o.reg2_rs = 1'b1;
                ctrl_o.wmem    = 1'b1;
                imm_type       = IMM_S;
                if (!(f3 inside {3'b000, 3'b001, 3'b010}))
                    ctrl_o.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_o.use_rs1 = 1'b1;
                ctrl_o.use_rs2 = 1'b1;
                ctrl_o.reg2_rs = 1'b1;
                imm_type       = IMM_B;
                if (f3 == F3_SLT || f3 == F3_SLTU)
                    ctrl_o.illegal = 1'b1;
            end
            OPC_JAL: begin
                ctrl_o.src1 = SRC1_PC;
                ctrl_o.wreg = 1'b1;
                imm_type    = IMM_J;
            end
            OPC_JALR: begin
                ctrl_o.use_rs1 = 1'b1;
                ctrl_o.wreg    = 1'b1;
                imm_type       = IMM_I;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase

        // An illegal instruction must not touch state or stall the pipe.
        if (ctrl_o.illegal) begin
            ctrl_o.wreg    = 1'b0;
            ctrl_o.wmem    = 1'b0;
            ctrl_o.rmem    = 1'b0;
            ctrl_o.use_rs1 = 1'b0;
            ctrl_o.use_rs2 = 1'b0;
            ctrl_o.reg2_rs = 1'b0;
            ctrl_o.src1    = SRC1_ZERO;
            ctrl_o.aluc    = '0;
            imm_type       = IMM_NONE;
        end
        if (inst_i[11:7] == 5'd0)
            ctrl_o.wreg = 1'b0;

        case (imm_type)
            IMM_I:   ctrl_o.imm = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:   ctrl_o.imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   ctrl_o.imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                                   inst_i[11:8], 1'b0};
            IMM_U:   ctrl_o.imm = {inst_i[31:12], 12'b0};
            IMM_J:   ctrl_o.imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                                   inst_i[30:21], 1'b0};
            IMM_SH:  ctrl_o.imm = {27'b0, inst_i[24:20]};
            default: ctrl_o.imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage: operand forwarding, load-use stall and the ID/EX register.
// ID_MULDIV_EN (in id_decode) enables RV32M decode.
module id_ex_stage
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = ID_XLEN,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned RA_W    = ID_RA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [31:0]             inst_i,
    output logic [RA_W-1:0]         rs1_addr_o,
    output logic [RA_W-1:0]         rs2_addr_o,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         rs2_data_i,
    input  logic [NUM_FWD-1:0]      fwd_wreg_i,
    input  logic [NUM_FWD*RA_W-1:0] fwd_wd_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_i,
    input  logic                    ex_rmem_i,
    input  logic [RA_W-1:0]         ex_wd_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         pc_o,
    output logic [6:0]              aluop_o,
    output logic [2:0]              alusel_o,
    output logic [6:0]              aluc_o,
    output logic [XLEN-1:0]         reg1_o,
    output logic [XLEN-1:0]         reg2_o,
    output logic [XLEN-1:0]         imm_o,
    output logic [RA_W-1:0]         wd_o,
    output logic                    wreg_o,
    output logic                    wmem_o,
    output logic                    rmem_o,
    output logic                    illegal_o
);

    id_ctrl_t        ctrl;
    id_ex_t          ex_d, ex_q;
    logic            valid_d, valid_q;
    logic [RA_W-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] chain1 [NUM_FWD+1];
    logic [XLEN-1:0] chain2 [NUM_FWD+1];
    logic            hazard, accept;

    id_decode u_decode (
        .inst_i (inst_i),
        .ctrl_o (ctrl)
    );

    assign rs1_addr   = inst_i[19:15];
    assign rs2_addr   = inst_i[24:20];
    assign rs1_addr_o = rs1_addr;
    assign rs2_addr_o = rs2_addr;

    // Priority chain from the oldest source down so the youngest match wins.
    assign chain1[NUM_FWD] = rs1_data_i;
    assign chain2[NUM_FWD] = rs2_data_i;
    for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
        assign chain1[k] = (fwd_wreg_i[k] && fwd_wd_i[k*RA_W +: RA_W] == rs1_addr)
                           ? fwd_wdata_i[k*XLEN +: XLEN] : chain1[k+1];
        assign chain2[k] = (fwd_wreg_i[k] && fwd_wd_i[k*RA_W +: RA_W] == rs2_addr)
                           ? fwd_wdata_i[k*XLEN +: XLEN] : chain2[k+1];
    end
    assign rs1_val = (rs1_addr == '0) ? '0 : chain1[0];
    assign rs2_val = (rs2_addr == '0) ? '0 : chain2[0];

    assign hazard = in_valid_i && ex_rmem_i && (ex_wd_i != '0) &&
                    ((ctrl.use_rs1 && rs1_addr == ex_wd_i) ||
                     (ctrl.use_rs2 && rs2_addr == ex_wd_i));
    assign in_ready_o = !hazard && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            ex_d.pc    = pc_i;
            ex_d.aluop = ctrl.aluop;
            ex_d.alusel = ctrl.alusel;
            ex_d.aluc  = ctrl.aluc;
            case (ctrl.src1)
                SRC1_RS: ex_d.reg1 = rs1_val;
                SRC1_PC: ex_d.reg1 = pc_i;
                default: ex_d.reg1 = '0;
            endcase
            ex_d.reg2    = ctrl.reg2_rs ? rs2_val : ctrl.imm;
            ex_d.imm     = ctrl.imm;
            ex_d.wd      = inst_i[11:7];
            ex_d.wreg    = ctrl.wreg;
            ex_d.wmem    = ctrl.wmem;
            ex_d.rmem    = ctrl.rmem;
            ex_d.illegal = ctrl.illegal;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign pc_o        = ex_q.pc;
    assign aluop_o     = ex_q.aluop;
    assign alusel_o    = ex_q.alusel;
    assign aluc_o      = ex_q.aluc;
    assign reg1_o      = ex_q.reg1;
    assign reg2_o      = ex_q.reg2;
    assign imm_o       = ex_q.imm;
    assign wd_o        = ex_q.wd;
    assign wreg_o      = ex_q.wreg;
    assign wmem_o      = ex_q.wmem;
    assign rmem_o      = ex_q.rmem;
    assign illegal_o   = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected fields queued on accept, compared on EX handshake.
module tb_id_ex_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_FWD = 2;
    localparam int unsigned RA_W    = 5;

    logic                    clk = 1'b0;
    logic                    rst_n, flush, in_valid, in_ready;
    logic [XLEN-1:0]         pc;
    logic [31:0]             inst;
    logic [RA_W-1:0]         rs1_addr, rs2_addr;
    logic [XLEN-1:0]         rs1_data, rs2_data;
    logic [NUM_FWD-1:0]      fwd_wreg;
    logic [NUM_FWD*RA_W-1:0] fwd_wd;
    logic [NUM_FWD*XLEN-1:0] fwd_wdata;
    logic                    ex_rmem;
    logic [RA_W-1:0]         ex_wd;
    logic                    out_valid, out_ready;
    logic [XLEN-1:0]         pc_o, reg1_o, reg2_o, imm_o;
    logic [6:0]              aluop_o, aluc_o;
    logic [2:0]              alusel_o;
    logic [RA_W-1:0]         wd_o;
    logic                    wreg_o, wmem_o, rmem_o, illegal_o;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .inst_i(inst),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
        .ex_rmem_i(ex_rmem), .ex_wd_i(ex_wd),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o), .aluc_o(aluc_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wmem_o(wmem_o), .rmem_o(rmem_o), .illegal_o(illegal_o)
    );

    // Register file model: x0 holds garbage on purpose, the stage must force 0.
    logic [XLEN-1:0] rf [32];
    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    typedef struct {
        logic [31:0] pc, reg1, reg2, imm;
        logic [6:0]  aluop;
        logic [2:0]  alusel;
        logic [6:0]  aluc;
        logic [4:0]  wd;
        logic [3:0]  ctl;
        bit          full;
    } exp_t;

    exp_t sb [$];
    exp_t cur_exp;
    int   checks = 0;
    int   errors = 0;
    bit   acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] im, input logic [6:0] op, input logic [2:0] sel,
                                input logic [6:0] c, input logic [4:0] d, input logic [3:0] ctl,
                                input bit full);
        exp_t e;
        e.pc = p; e.reg1 = r1; e.reg2 = r2; e.imm = im;
        e.aluop = op; e.alusel = sel; e.aluc = c; e.wd = d; e.ctl = ctl; e.full = full;
        return e;
    endfunction

    // One cycle: compare on EX handshake, queue on accept, then advance to next negedge.
    task automatic tick();
        exp_t e;
        #1;
        acc = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ctl", 64'({wreg_o, wmem_o, rmem_o, illegal_o}), 64'(e.ctl));
                if (e.full) begin
                    check("pc", 64'(pc_o), 64'(e.pc));
                    check("alu", 64'({aluop_o, alusel_o, aluc_o, wd_o}),
                          64'({e.aluop, e.alusel, e.aluc, e.wd}));
                    check("reg1", 64'(reg1_o), 64'(e.reg1));
                    check("reg2", 64'(reg2_o), 64'(e.reg2));
                    check("imm", 64'(imm_o), 64'(e.imm));
                end
            end
        end
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back(cur_exp);
            acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] p, input logic [31:0] i, input exp_t e);
        pc = p; inst = i; cur_exp = e; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'h1000 + 32'(r);
        rf[0] = 32'hDEADBEEF;
        rf[2] = 32'd7;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; pc = '0; inst = 32'h00000013;
        fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0; ex_rmem = 1'b0; ex_wd = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_regs", 64'({reg1_o, reg2_o}), 64'd0);
        check("rst_ctl", 64'({wreg_o, wmem_o, rmem_o, illegal_o, wd_o}), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // addi x1,x0,5
        issue(32'h100, 32'h00500093, mk(32'h100, 0, 5, 5, 7'h13, 3'd0, 7'h00, 5'd1, 4'b1000, 1));
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("rs_addr", 64'({rs1_addr, rs2_addr}), 64'({5'd0, 5'd5}));
        drain();

        // add x3,x1,x2 under several forwarding patterns
        fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'hBB, 32'hAA};
        issue(32'h104, 32'h002081B3, mk(32'h104, 32'hAA, 7, 0, 7'h33, 3'd0, 7'h00, 5'd3, 4'b1000, 1));
        fwd_wreg = 2'b10;
        issue(32'h108, 32'h002081B3, mk(32'h108, 32'hBB, 7, 0, 7'h33, 3'd0, 7'h00, 5'd3, 4'b1000, 1));
        fwd_wd = {5'd2, 5'd1};
        issue(32'h10C, 32'h002081B3, mk(32'h10C, 32'h1001, 32'hBB, 0, 7'h33, 3'd0, 7'h00, 5'd3, 4'b1000, 1));
        fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0};
        issue(32'h110, 32'h002001B3, mk(32'h110, 0, 7, 0, 7'h33, 3'd0, 7'h00, 5'd3, 4'b1000, 1));
        fwd_wreg = '0;
        drain();

        // load-use on x5: add x6,x5,x0 stalls one cycle, bubble goes to EX
        ex_rmem = 1'b1; ex_wd = 5'd5;
        pc = 32'h120; inst = 32'h00028333; in_valid = 1'b1;
        #1;
        check("hz_ready", 64'(in_ready), 64'd0);
        tick();
        check("hz_bubble", 64'(out_valid), 64'd0);
        ex_rmem = 1'b0;
        issue(32'h120, 32'h00028333, mk(32'h120, 32'h1005, 0, 0, 7'h33, 3'd0, 7'h00, 5'd6, 4'b1000, 1));
        ex_rmem = 1'b1;
        inst = 32'h00500333; in_valid = 1'b1;
        #1;
        check("hz_rs2", 64'(in_ready), 64'd0);
        inst = 32'h00500493;
        #1;
        check("hz_unused_rs2", 64'(in_ready), 64'd1);
        issue(32'h124, 32'h00500493, mk(32'h124, 0, 5, 5, 7'h13, 3'd0, 7'h00, 5'd9, 4'b1000, 1));
        ex_rmem = 1'b0;
        drain();

        // EX backpressure: sw held for 3 cycles, then lw accepted
        out_ready = 1'b0;
        issue(32'h130, 32'h0020A423, mk(32'h130, 32'h1001, 7, 8, 7'h23, 3'd2, 7'h00, 5'd8, 4'b0100, 1));
        pc = 32'h134; inst = 32'hFFC0A203; in_valid = 1'b1;
        cur_exp = mk(32'h134, 32'h1001, 32'hFFFFFFFC, 32'hFFFFFFFC, 7'h03, 3'd2, 7'h00, 5'd4, 4'b1010, 1);
        repeat (3) begin
            #1;
            check("stall_ready", 64'(in_ready), 64'd0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_reg2", 64'(reg2_o), 64'd7);
            tick();
        end
        out_ready = 1'b1;
        issue(32'h134, 32'hFFC0A203, cur_exp);
        drain();

        // flush kills the held instruction and the incoming one
        out_ready = 1'b0;
        issue(32'h140, 32'h00500093, mk(32'h140, 0, 5, 5, 7'h13, 3'd0, 7'h00, 5'd1, 4'b1000, 1));
        flush = 1'b1; in_valid = 1'b1; inst = 32'h00500493;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_held", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        issue(32'h144, 32'h123453B7, mk(32'h144, 0, 32'h12345000, 32'h12345000, 7'h37, 3'd5, 7'h00, 5'd7, 4'b1000, 1));
        flush = 1'b1; in_valid = 1'b1; inst = 32'h00500093;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_in", 64'(out_valid), 64'd0);

        // auipc, jal, beq, srai, illegal branch, RV32M encoding
        issue(32'h200, 32'h00001597, mk(32'h200, 32'h200, 32'h1000, 32'h1000, 7'h17, 3'd1, 7'h00, 5'd11, 4'b1000, 1));
        issue(32'h300, 32'hFF9FF0EF, mk(32'h300, 32'h300, 32'hFFFFFFF8, 32'hFFFFFFF8, 7'h6F, 3'd7, 7'h00, 5'd1, 4'b1000, 1));
        issue(32'h304, 32'h00208863, mk(32'h304, 32'h1001, 7, 16, 7'h63, 3'd0, 7'h00, 5'd16, 4'b0000, 1));
        issue(32'h308, 32'h4030D613, mk(32'h308, 32'h1001, 3, 3, 7'h13, 3'd5, 7'h20, 5'd12, 4'b1000, 1));
        issue(32'h30C, 32'h0020A863, mk(32'h30C, 0, 0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 4'b0001, 0));
`ifdef ID_MULDIV_EN
        issue(32'h400, 32'h02208033, mk(32'h400, 32'h1001, 7, 0, 7'h33, 3'd0, 7'h01, 5'd0, 4'b0000, 1));
`else
        issue(32'h400, 32'h02208033, mk(32'h400, 0, 0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 4'b0001, 0));
`endif
        drain();

        // reset while EX stalls: nothing stale may emerge afterwards
        out_ready = 1'b0;
        issue(32'h500, 32'h00500093, mk(32'h500, 0, 5, 5, 7'h13, 3'd0, 7'h00, 5'd1, 4'b1000, 1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", 64'(out_valid), 64'd0);
        sb.delete();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        check("no_stale", 64'(out_valid), 64'd0);

        check("sb_left", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
